// File: rtl/uart_pkg.sv
// Shared UART definitions: bit-time computation, FSM state encoding and line levels.
// Imported by both the transmitter and the companion receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  // Clocks per serial bit; integer divide keeps TX and RX on identical timing.
  function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO buffering words ahead of the serializer.
// Head entry is presented combinationally on rd_data.
module uart_tx_fifo #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic             w_push;
  logic             w_pop;

  // The extra top pointer bit separates the full and empty cases when the index bits match.
  assign empty   = (r_wptr == r_rptr);
  assign full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push  = wr_en && !full;
  assign w_pop   = rd_en && !empty;
  assign rd_data = r_mem[r_rptr[AW-1:0]];

  // Read and write pointer update
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wptr <= {(AW+1){1'b0}};
      r_rptr <= {(AW+1){1'b0}};
    end else begin
      if (w_push) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
      if (w_pop)  r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1-style UART transmitter: FIFO-buffered ready/valid input, registered serial line.
// Back-to-back frames leave with no idle gap between stop and the next start bit.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_in_valid,
  output logic             data_in_ready,
  output logic             serial_out,
  output logic             tx_busy
);

  localparam int SET = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
  localparam int CW  = (SET > 1) ? $clog2(SET) : 1;
  localparam int BW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  uart_state_e      r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [BW-1:0]    r_bit, w_bit_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic             r_serial, w_line_nxt;
  logic             w_pop, w_full, w_empty, w_symbol_edge;
  logic [WIDTH-1:0] w_head;

  uart_tx_fifo #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (data_in_valid),
    .wr_data (data_in),
    .full    (w_full),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .empty   (w_empty)
  );

  assign w_symbol_edge = (r_cnt == CW'(SET - 1));
  assign data_in_ready = !w_full;
  assign tx_busy       = (r_state != IDLE) || !w_empty;
  assign serial_out    = r_serial;

  // State, timer, shift register and line flop
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_cnt    <= {CW{1'b0}};
      r_bit    <= {BW{1'b0}};
      r_shift  <= {WIDTH{1'b0}};
      r_serial <= LINE_IDLE;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_bit    <= w_bit_nxt;
      r_shift  <= w_shift_nxt;
      r_serial <= w_line_nxt;
    end
  end

  // Next-state logic; the line level follows the current state one clock later
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_symbol_edge ? {CW{1'b0}} : r_cnt + CW'(1);
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_line_nxt  = LINE_IDLE;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt  = {CW{1'b0}};
        w_line_nxt = LINE_IDLE;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_state_nxt = START;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      START: begin
        w_line_nxt = LINE_START;
        if (w_symbol_edge) begin
          w_bit_nxt   = {BW{1'b0}};
          w_state_nxt = DATA;
        end else begin
          w_state_nxt = START;
        end
      end
      DATA: begin
        w_line_nxt = r_shift[0];
        if (w_symbol_edge) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit == BW'(WIDTH - 1)) begin
            w_state_nxt = STOP;
          end else begin
            w_bit_nxt = r_bit + BW'(1);
          end
        end else begin
          w_state_nxt = DATA;
        end
      end
      STOP: begin
        w_line_nxt = LINE_STOP;
        if (w_symbol_edge && !w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_state_nxt = START;
        end else if (w_symbol_edge) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = STOP;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
Serializes parallel words onto an asynchronous serial line using 8N1-style framing: one start bit (0), WIDTH data bits LSB first, one stop bit (1). Words enter through a ready/valid interface and are buffered in a small internal FIFO, so back-to-back frames go out with no idle gap. It pairs with the lab UART receiver on the same link and uses the same CLOCK_FREQ/BAUD_RATE timing convention.

Parameters:
CLOCK_FREQ, 100_000_000, system clock frequency in Hz
BAUD_RATE, 115_200, line rate in bits/s; SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE (integer divide), in clocks per bit
WIDTH, 8, data bits per frame
FIFO_DEPTH, 4, input buffer entries; power of two, minimum 2

Ports:
clk  input  1  system clock; all logic on rising edge
reset_n  input  1  synchronous, active-low reset
data_in  input  WIDTH  word to transmit
data_in_valid  input  1  producer has a word on data_in
data_in_ready  output  1  high when the FIFO is not full
serial_out  output  1  serial line; idles high; registered output
tx_busy  output  1  high while a frame is on the line or the FIFO is non-empty

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset: while reset_n=0 at a clk edge, serial_out<=1, FIFO emptied, FSM<=IDLE, all counters<=0. data_in_ready=1 and tx_busy=0 from the first edge after reset_n rises. Reset mid-frame aborts the frame; the line returns high on that edge and no partial frame resumes.
- Handshake: a word is accepted on an edge where data_in_valid && data_in_ready. data_in_ready = !full. There is no pass-through when full, even if a pop happens in the same cycle. data_in is ignored when valid=0. Valid may be held high across multiple words.
- FIFO: ptr width $clog2(FIFO_DEPTH)+1, with an extra wrap bit to distinguish full from empty. Push and pop in the same cycle are both legal when not full and not empty, and the count is unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states:
  IDLE: serial_out=1. If FIFO non-empty: pop the head into shift register, clear clock_counter, go to START.
  START: serial_out=0 for SYMBOL_EDGE_TIME clocks, then go to DATA with bit_idx=0.
  DATA: serial_out=shift[0] for SYMBOL_EDGE_TIME clocks, then shift right and bit_idx++. After bit_idx==WIDTH-1 completes, go to STOP.
  STOP: serial_out=1 for SYMBOL_EDGE_TIME clocks. At the end, if FIFO non-empty, pop and go directly to START with no gap; otherwise go to IDLE.
- Symbol timer: clock_counter counts 0..SYMBOL_EDGE_TIME-1. symbol_edge = (clock_counter == SYMBOL_EDGE_TIME-1); the counter is cleared on symbol_edge and on leaving IDLE.
- Latency: word accepted at edge T into an empty FIFO in IDLE. Pop occurs at T+1 and serial_out falls at T+2. Frame length is exactly (WIDTH+2)*SYMBOL_EDGE_TIME clocks.
- serial_out is driven from a flop and is glitch-free.
- tx_busy = (state != IDLE) || !empty.
- The shift register is loaded only on pop. Changing data_in after acceptance has no effect.

Decomposition:
- Shared package uart_pkg holds: SYMBOL_EDGE_TIME computation, the state encoding localparams (IDLE, START, DATA, STOP), and the idle/start/stop line levels. The receiver uses the same package.
- One sub-module: uart_tx_fifo (parameters WIDTH, FIFO_DEPTH; ports clk, reset_n, wr_en, wr_data, full, rd_en, rd_data, empty). The data output is combinational from the head entry.

Test Plan:
All tests use CLOCK_FREQ=1000, BAUD_RATE=100 (10 clk/bit), WIDTH=8, FIFO_DEPTH=4.
- Reset: hold reset_n=0 for 3 edges -> serial_out=1, data_in_ready=1, tx_busy=0. Line stays high for 50 idle cycles.
- Single word 0xA5 at edge T -> serial_out falls at T+2. Sampling mid-bit gives 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop), each bit 10 clk wide. tx_busy falls after 100 clk of frame.
- Burst: hold valid with 0x00, 0xFF, 0x55, 0x3C, 0x81, 0x7E -> data_in_ready drops when 4 words are buffered. All 6 frames go out contiguously (600 clk total, no idle high between stop and next start) and in order. The loopback receiver reports the same 6 words.
- Full boundary: FIFO full while a frame is in STOP end -> no word accepted in the pop cycle. data_in_ready rises on the next edge.
- Reset mid-frame: assert reset_n=0 during DATA bit 3 of 0xF0 -> serial_out=1 on the next edge. The FIFO is empty and the truncated frame is not retransmitted. A new word 0x0F afterwards transmits correctly.
- Valid without ready and data changes: toggle data_in while valid=0 and while the FIFO is full -> only words with valid&&ready appear on the line.
